// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_scheduler
// Description : Whac-A-Mole scheduler. It waits a random number of ms, raises
//               one mole, judges button presses as hit or miss, then shows the
//               result. Define SPEEDUP_EN to shorten the up-time after each hit.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler #(
    parameter int CLKS_PER_MS = 50000,
    parameter int NUM_MOLES   = 4,
    parameter int RAND_WIDTH  = 11,
    parameter int UP_TIME_MS  = 800,
    parameter int SHOW_MS     = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [RAND_WIDTH-1:0] random_value,
    input  logic [NUM_MOLES-1:0]  buttons,
    output logic [NUM_MOLES-1:0]  mole_mask,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  busy
);

    localparam int c_PS_W   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int c_MS_W   = (RAND_WIDTH > 11) ? RAND_WIDTH : 11;
    localparam int c_SLOT_W = $clog2(NUM_MOLES);

    localparam logic [c_PS_W-1:0]    c_PS_LAST  = c_PS_W'(CLKS_PER_MS - 1);
    localparam logic [c_PS_W-1:0]    c_PS_ONE   = c_PS_W'(1);
    localparam logic [c_MS_W-1:0]    c_MS_ONE   = c_MS_W'(1);
    localparam logic [c_MS_W-1:0]    c_UP_TIME  = c_MS_W'(UP_TIME_MS);
    localparam logic [c_MS_W-1:0]    c_SHOW     = c_MS_W'(SHOW_MS);
    localparam logic [NUM_MOLES-1:0] c_ONE_MOLE = NUM_MOLES'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_UP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PS_W-1:0]    r_presc;
    logic [c_MS_W-1:0]    r_ms;
    logic [c_MS_W-1:0]    r_delay;
    logic [c_SLOT_W-1:0]  r_slot;
    logic [NUM_MOLES-1:0] r_btn_prev;

    logic                 w_tick;
    logic [c_MS_W-1:0]    w_ms_next;
    logic [c_MS_W-1:0]    w_up_limit;
    logic [c_MS_W-1:0]    w_delay_cap;
    logic [c_SLOT_W-1:0]  w_slot_cap;
    logic [NUM_MOLES-1:0] w_slot_onehot;
    logic [NUM_MOLES-1:0] w_rise;
    logic                 w_press;
    logic                 w_hit;
    logic                 w_up_done;
    logic                 w_enter_wait;

    assign w_tick        = (r_presc == c_PS_LAST);
    assign w_ms_next     = r_ms + c_MS_ONE;
    assign w_delay_cap   = (random_value == '0) ? c_MS_ONE : c_MS_W'(random_value);
    assign w_slot_cap    = c_SLOT_W'(random_value % RAND_WIDTH'(NUM_MOLES));
    assign w_slot_onehot = c_ONE_MOLE << r_slot;
    assign w_rise        = buttons & ~r_btn_prev;

    // A press on the timeout cycle wins, so w_press is checked before w_up_done.
    assign w_press      = enable && (r_state == S_UP) && (w_rise != '0);
    assign w_hit        = w_press && (w_rise == w_slot_onehot);
    assign w_up_done    = w_press || (w_tick && (w_ms_next == w_up_limit));
    assign w_enter_wait = enable && ((r_state == S_IDLE) ||
                          ((r_state == S_SHOW) && w_tick && (w_ms_next == c_SHOW)));

`ifdef SPEEDUP_EN
    localparam logic [c_MS_W-1:0] c_UP_FLOOR = c_MS_W'(300);
    localparam logic [c_MS_W-1:0] c_UP_STEP  = c_MS_W'(50);

    logic [c_MS_W-1:0] r_up_time;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_up_time <= c_UP_TIME;
        end else if (w_hit) begin
            r_up_time <= (r_up_time >= c_UP_FLOOR + c_UP_STEP) ? (r_up_time - c_UP_STEP)
                                                               : c_UP_FLOOR;
        end
    end

    assign w_up_limit = r_up_time;
`else
    assign w_up_limit = c_UP_TIME;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_ms       <= '0;
            r_delay    <= '0;
            r_slot     <= '0;
            r_btn_prev <= '0;
            mole_mask  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_btn_prev <= buttons;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            r_presc    <= w_tick ? '0 : (r_presc + c_PS_ONE);
            if (w_tick) begin
                r_ms <= w_ms_next;
            end

            if (!enable) begin
                r_state   <= S_IDLE;
                mole_mask <= '0;
                busy      <= 1'b0;
                r_presc   <= '0;
                r_ms      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (w_tick && (w_ms_next == r_delay)) begin
                            r_state   <= S_UP;
                            mole_mask <= w_slot_onehot;
                            r_presc   <= '0;
                            r_ms      <= '0;
                        end
                    end
                    S_UP: begin
                        if (w_up_done) begin
                            r_state    <= S_SHOW;
                            mole_mask  <= '0;
                            hit_pulse  <= w_hit;
                            miss_pulse <= !w_hit;
                            r_presc    <= '0;
                            r_ms       <= '0;
                        end
                    end
                    S_SHOW: ;
                    default: r_state <= S_IDLE;
                endcase

                // Both IDLE and the end of SHOW start a fresh wait from random_value.
                if (w_enter_wait) begin
                    r_state   <= S_WAIT;
                    busy      <= 1'b1;
                    mole_mask <= '0;
                    r_delay   <= w_delay_cap;
                    r_slot    <= w_slot_cap;
                    r_presc   <= '0;
                    r_ms      <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// Testbench for mole_scheduler: scenario table, hand-written corner sequences
// and a randomized run, all checked every cycle against a countdown model.
module tb_mole_scheduler;

    localparam int C_CLK  = 2;
    localparam int C_UP   = 800;
    localparam int C_SHOW = 200;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [10:0] random_value;
    logic [3:0]  buttons;
    logic [3:0]  mole_mask;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        busy;

    mole_scheduler #(
        .CLKS_PER_MS (C_CLK),
        .NUM_MOLES   (4),
        .RAND_WIDTH  (11),
        .UP_TIME_MS  (C_UP),
        .SHOW_MS     (C_SHOW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .random_value (random_value),
        .buttons      (buttons),
        .mole_mask    (mole_mask),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_cyc = 0;

    // Reference model: phase plus cycles left in it, no prescaler.
    int unsigned m_mode;   // 0 idle, 1 wait, 2 up, 3 show
    int unsigned m_left;
    int unsigned m_slot;
    int unsigned m_up_ms;
    logic [3:0]  m_prev;
    logic        m_hit;
    logic        m_miss;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, n_cyc, act, exp);
        end
    endfunction

    function automatic void model_start_wait();
        int unsigned rv;
        rv      = random_value;
        m_mode  = 1;
        m_left  = ((rv == 0) ? 1 : rv) * C_CLK;
        m_slot  = rv % 4;
    endfunction

    function automatic void model_show();
        m_mode = 3;
        m_left = C_SHOW * C_CLK;
    endfunction

    function automatic void model_edge();
        logic [3:0] rises;
        m_hit  = 1'b0;
        m_miss = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_left  = 0;
            m_slot  = 0;
            m_prev  = '0;
            m_up_ms = C_UP;
            return;
        end
        rises  = buttons & ~m_prev;
        m_prev = buttons;
        if (!enable) begin
            m_mode  = 0;
            m_up_ms = C_UP;
            return;
        end
        case (m_mode)
            0: model_start_wait();
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = m_up_ms * C_CLK;
                end
            end
            2: begin
                if (rises != 4'b0000) begin
                    if (rises == (4'b0001 << m_slot)) begin
                        m_hit = 1'b1;
`ifdef SPEEDUP_EN
                        m_up_ms = (m_up_ms < 350) ? 300 : m_up_ms - 50;
`endif
                    end else begin
                        m_miss = 1'b1;
                    end
                    model_show();
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_miss = 1'b1;
                        model_show();
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) model_start_wait();
            end
        endcase
    endfunction

    function automatic logic [6:0] model_out();
        logic [3:0] mask;
        mask = (m_mode == 2) ? (4'b0001 << m_slot) : 4'b0000;
        return {mask, m_hit, m_miss, (m_mode != 0)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        n_cyc++;
        @(negedge clk);
        check("cycle", {25'd0, mole_mask, hit_pulse, miss_pulse, busy}, {25'd0, model_out()});
    endtask

    task automatic wait_mole(input int budget, output int n);
        n = 0;
        while (mole_mask == 4'b0000 && n < budget) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_pulse(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(hit_pulse || miss_pulse) && n < budget);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        buttons = 4'b0000;
        repeat (3) cyc();
        check("reset_outputs", {25'd0, mole_mask, hit_pulse, miss_pulse, busy}, 32'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        int         rv;
        logic [3:0] press;
        int         off;
        logic [3:0] exp_mask;
        int         exp_wait;
        int         exp_resp;
        logic       exp_hit;
        logic       exp_miss;
        int         exp_next;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int seen;
        reset        = 1'b1;
        enable       = 1'b0;
        random_value = '0;
        buttons      = '0;
        m_mode = 0; m_left = 0; m_slot = 0; m_up_ms = C_UP; m_prev = '0;
        m_hit = 1'b0; m_miss = 1'b0;

        tbl[0] = '{200,  4'b0001, 5,    4'b0001, 400,  6,    1'b1, 1'b0, 800};
        tbl[1] = '{203,  4'b1000, 10,   4'b1000, 406,  11,   1'b1, 1'b0, 806};
        tbl[2] = '{201,  4'b0100, 3,    4'b0010, 402,  4,    1'b0, 1'b1, 802};
        tbl[3] = '{202,  4'b0000, 0,    4'b0100, 404,  1600, 1'b0, 1'b1, 804};
        tbl[4] = '{0,    4'b1001, 0,    4'b0001, 2,    1,    1'b0, 1'b1, 402};
        tbl[5] = '{1223, 4'b1000, 1599, 4'b1000, 2446, 1600, 1'b1, 1'b0, 2846};
        tbl[6] = '{5,    4'b0010, 0,    4'b0010, 10,   1,    1'b1, 1'b0, 410};

        for (int i = 0; i < 7; i++) begin
            random_value = 11'(tbl[i].rv);
            do_reset();
            enable = 1'b1;
            cyc();
            wait_mole(5000, n);
            check("wait_len", n, tbl[i].exp_wait);
            check("mole_mask", {28'd0, mole_mask}, {28'd0, tbl[i].exp_mask});
            if (tbl[i].press != 4'b0000) begin
                repeat (tbl[i].off) cyc();
                buttons = tbl[i].press;
            end
            wait_pulse(2000, n);
            check("resp_len", tbl[i].off + n, tbl[i].exp_resp);
            check("hit_miss", {30'd0, hit_pulse, miss_pulse}, {30'd0, tbl[i].exp_hit, tbl[i].exp_miss});
            check("mask_at_pulse", {28'd0, mole_mask}, 32'd0);
            buttons = 4'b0000;
            cyc();
            check("pulse_one_cycle", {30'd0, hit_pulse, miss_pulse}, 32'd0);
            wait_mole(6000, n);
            check("show_plus_wait", n + 1, tbl[i].exp_next);
        end

        // Button held across the mole rising must be released and re-pressed.
        random_value = 11'd201;
        do_reset();
        buttons = 4'b0010;
        enable  = 1'b1;
        cyc();
        wait_mole(5000, n);
        check("held_mask", {28'd0, mole_mask}, 32'h2);
        seen = 0;
        repeat (20) begin
            cyc();
            if (hit_pulse || miss_pulse) seen++;
        end
        check("held_no_pulse", seen, 0);
        buttons = 4'b0000;
        cyc();
        cyc();
        buttons = 4'b0010;
        cyc();
        check("repress_hit", {30'd0, hit_pulse, miss_pulse}, 32'h2);
        buttons = 4'b0000;

        // enable dropped while a mole is up.
        random_value = 11'd200;
        do_reset();
        enable = 1'b1;
        cyc();
        wait_mole(5000, n);
        repeat (10) cyc();
        enable = 1'b0;
        cyc();
        check("enable_drop", {25'd0, mole_mask, hit_pulse, miss_pulse, busy}, 32'd0);
        repeat (3) cyc();

        // reset in the middle of a wait.
        random_value = 11'd300;
        enable = 1'b1;
        cyc();
        repeat (50) cyc();
        check("busy_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        cyc();
        check("reset_mid_wait", {25'd0, mole_mask, hit_pulse, miss_pulse, busy}, 32'd0);
        reset = 1'b0;

`ifdef SPEEDUP_EN
        // Up-time shrinks by 50 ms per hit and bottoms out at 300 ms.
        random_value = 11'd4;
        do_reset();
        enable = 1'b1;
        cyc();
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                wait_mole(5000, n);
                buttons = 4'b0001;
                cyc();
                check("speedup_hit", {30'd0, hit_pulse, miss_pulse}, 32'h2);
                buttons = 4'b0000;
            end
            wait_mole(5000, n);
            wait_pulse(2000, n);
            check("speedup_timeout", n, ((800 - 50 * i) < 300 ? 300 : (800 - 50 * i)) * C_CLK);
        end
`endif

        // Randomized traffic against the model.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            reset = ($urandom_range(0, 4999) == 0);
            if (enable && $urandom_range(0, 2999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            if ($urandom_range(0, 49) == 0) random_value = 11'($urandom_range(0, 2047));
            else random_value = 11'($urandom_range(0, 40));
            if ($urandom_range(0, 29) == 0) buttons = buttons ^ (4'b0001 << $urandom_range(0, 3));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog cyc=%0d got=running want=finished", n_cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
